convolution_coprocessor_acc: RTL and testbench

Sequential signed accumulator for the convolution coprocessor datapath. It is the additive counterpart to the coprocessor's combinational subtractor. It sums a programmed number of DATA_WIDTH two's-complement terms, such as products or differences streamed from upstream, into a saturating ACC_WIDTH result. It then presents that result on a valid/ready output port. The block sits between the per-tap arithmetic and the result writeback stage.

---
 rtl/convolution_coprocessor_acc.sv | 104 ++++++++++
 tb/tb_convolution_coprocessor_acc.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/convolution_coprocessor_acc.sv
// Saturating signed accumulator for the convolution coprocessor datapath.
// Sums a programmed number of signed terms into a clamped result and
// offers it on a valid/ready port. All outputs come from registers or
// from the FSM state, so no input reaches an output combinationally.
module convolution_coprocessor_acc #(
  parameter int DATA_WIDTH = 5,
  parameter int ACC_WIDTH  = 8,
  parameter int LEN_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  len,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [ACC_WIDTH-1:0]  out_data,
  output logic                  out_ovf,
  input  logic                  out_ready,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                      state;
  logic [LEN_WIDTH-1:0]        count;
  logic signed [ACC_WIDTH-1:0] acc;
  logic                        ovf;

  logic signed [ACC_WIDTH:0]   term_ext;
  logic signed [ACC_WIDTH:0]   sum_ext;

  // Sum one guard bit wider than the accumulator: it cannot overflow,
  // and disagreement between its top two bits flags a result out of range.
  function automatic logic is_ovf(input logic signed [ACC_WIDTH:0] s);
    return s[ACC_WIDTH] != s[ACC_WIDTH-1];
  endfunction

  // Clamp the guarded sum to the accumulator range; the guard bit gives
  // the direction of the overflow.
  function automatic logic signed [ACC_WIDTH-1:0] sat(input logic signed [ACC_WIDTH:0] s);
    if (is_ovf(s)) begin
      if (s[ACC_WIDTH]) return {1'b1, {(ACC_WIDTH-1){1'b0}}};
      else              return {1'b0, {(ACC_WIDTH-1){1'b1}}};
    end
    return s[ACC_WIDTH-1:0];
  endfunction

  // Sign-extend the incoming term and form the guarded sum with the
  // current (possibly already clamped) accumulator.
  always_comb begin
    term_ext = {{(ACC_WIDTH+1-DATA_WIDTH){in_data[DATA_WIDTH-1]}}, in_data};
    sum_ext  = {acc[ACC_WIDTH-1], acc} + term_ext;
  end

  // Control FSM with accumulator, remaining count and sticky overflow.
  // A mid-operation reset discards the partial sum outright.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
      acc   <= '0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            count <= len;
            acc   <= '0;
            ovf   <= 1'b0;
            state <= (len == '0) ? DONE : ACCUM;
          end
        end
        ACCUM: begin
          if (in_valid) begin
            acc   <= sat(sum_ext);
            if (is_ovf(sum_ext)) ovf <= 1'b1;
            count <= count - LEN_WIDTH'(1);
            if (count == LEN_WIDTH'(1)) state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Handshake and status outputs decode directly from the state register.
  always_comb begin
    in_ready  = (state == ACCUM);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
    out_data  = acc;
    out_ovf   = ovf;
  end

endmodule

// File: tb/tb_convolution_coprocessor_acc.sv
// Directed testbench for convolution_coprocessor_acc: linear sequence of
// steps with hand-computed expected values checked by immediate assertions.
module tb_convolution_coprocessor_acc;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] len;
  logic       in_valid;
  logic [4:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ovf;
  logic       out_ready;
  logic       busy;

  int vectors = 0;
  int fails   = 0;

  convolution_coprocessor_acc #(
    .DATA_WIDTH(5),
    .ACC_WIDTH (8),
    .LEN_WIDTH (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .len      (len),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ovf  (out_ovf),
    .out_ready(out_ready),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Advance one rising edge, then settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one term for exactly one edge.
  task automatic feed(input logic [4:0] d);
    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid = 1'b0;
  endtask

  task automatic begin_acc(input logic [3:0] n);
    start = 1'b1;
    len   = n;
    step();
    start = 1'b0;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout vectors=%0d", vectors);
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    rst = 1'b1; start = 1'b0; len = 4'd0; in_valid = 1'b0;
    in_data = 5'h00; out_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    chk("rst_in_ready",  {31'd0, in_ready},  32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data",  {24'd0, out_data},  32'd0);
    chk("rst_out_ovf",   {31'd0, out_ovf},   32'd0);
    chk("rst_busy",      {31'd0, busy},      32'd0);

    // len=4: 3 - 5 + 7 - 16 = -11
    begin_acc(4'd4);
    chk("t1_in_ready", {31'd0, in_ready}, 32'd1);
    chk("t1_busy",     {31'd0, busy},     32'd1);
    feed(5'h03); feed(5'h1B); feed(5'h07);
    chk("t1_not_yet_valid", {31'd0, out_valid}, 32'd0);
    feed(5'h10);
    chk("t1_out_valid", {31'd0, out_valid}, 32'd1);
    chk("t1_in_ready0", {31'd0, in_ready},  32'd0);
    chk("t1_out_data",  {24'd0, out_data},  32'h0F5);
    chk("t1_out_ovf",   {31'd0, out_ovf},   32'd0);
    consume();
    chk("t1_after_valid", {31'd0, out_valid}, 32'd0);
    chk("t1_after_busy",  {31'd0, busy},      32'd0);

    // len=15 of +15 saturates high
    begin_acc(4'd15);
    for (int i = 0; i < 15; i++) feed(5'h0F);
    chk("t2a_out_valid", {31'd0, out_valid}, 32'd1);
    chk("t2a_out_data",  {24'd0, out_data},  32'h07F);
    chk("t2a_out_ovf",   {31'd0, out_ovf},   32'd1);
    consume();
    // len=15 of -16 saturates low
    begin_acc(4'd15);
    chk("t2b_ovf_cleared", {31'd0, out_ovf}, 32'd0);
    for (int i = 0; i < 15; i++) feed(5'h10);
    chk("t2b_out_data", {24'd0, out_data}, 32'h080);
    chk("t2b_out_ovf",  {31'd0, out_ovf},  32'd1);
    consume();

    // len=3 with stalls: 15 + 15 - 16 = 14
    begin_acc(4'd3);
    feed(5'h0F);
    for (int i = 0; i < 3; i++) begin
      in_data = 5'h0A;
      step();
      chk("t3_stall_ready", {31'd0, in_ready}, 32'd1);
    end
    feed(5'h0F);
    for (int i = 0; i < 3; i++) step();
    chk("t3_stall_no_valid", {31'd0, out_valid}, 32'd0);
    feed(5'h10);
    chk("t3_out_valid", {31'd0, out_valid}, 32'd1);
    chk("t3_out_data",  {24'd0, out_data},  32'h00E);
    chk("t3_out_ovf",   {31'd0, out_ovf},   32'd0);
    consume();

    // len=0 goes straight to DONE; start/in_valid ignored while held
    begin_acc(4'd0);
    chk("t4_out_valid", {31'd0, out_valid}, 32'd1);
    chk("t4_out_data",  {24'd0, out_data},  32'd0);
    chk("t4_out_ovf",   {31'd0, out_ovf},   32'd0);
    for (int i = 0; i < 5; i++) begin
      start = (i == 2); len = 4'd5;
      in_valid = (i == 2); in_data = 5'h07;
      step();
      chk("t4_hold_valid", {31'd0, out_valid}, 32'd1);
      chk("t4_hold_data",  {24'd0, out_data},  32'd0);
      chk("t4_hold_ready", {31'd0, in_ready},  32'd0);
    end
    start = 1'b1; len = 4'd2; in_valid = 1'b0; out_ready = 1'b1;
    step();
    start = 1'b0; out_ready = 1'b0;
    chk("t4_consumed_valid", {31'd0, out_valid}, 32'd0);
    chk("t4_start_ignored",  {31'd0, busy},      32'd0);
    step();
    chk("t4_still_idle", {31'd0, busy}, 32'd0);

    // rst aborts after two terms
    begin_acc(4'd5);
    feed(5'h03); feed(5'h04);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5_rst_in_ready",  {31'd0, in_ready},  32'd0);
    chk("t5_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("t5_rst_out_data",  {24'd0, out_data},  32'd0);
    chk("t5_rst_out_ovf",   {31'd0, out_ovf},   32'd0);
    chk("t5_rst_busy",      {31'd0, busy},      32'd0);
    begin_acc(4'd1);
    feed(5'h19);
    chk("t5_out_valid", {31'd0, out_valid}, 32'd1);
    chk("t5_out_data",  {24'd0, out_data},  32'h0F9);
    consume();

    // Saturate then recover: 9 x 15 clamps to 127, then -16 -> 111.
    // out_ready held high beforehand: valid lasts exactly one cycle.
    out_ready = 1'b1;
    begin_acc(4'd10);
    for (int i = 0; i < 9; i++) feed(5'h0F);
    chk("t6_mid_sat", {24'd0, out_data}, 32'h07F);
    feed(5'h10);
    chk("t6_out_valid", {31'd0, out_valid}, 32'd1);
    chk("t6_out_data",  {24'd0, out_data},  32'd111);
    chk("t6_out_ovf",   {31'd0, out_ovf},   32'd1);
    step();
    out_ready = 1'b0;
    chk("t6_one_cycle_valid", {31'd0, out_valid}, 32'd0);
    chk("t6_idle",            {31'd0, busy},      32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
